// File: rtl/program_loader.sv
// Boot/IO loader: pulls a length-prefixed program image from the UART into instruction RAM,
// starts the core, then streams a fixed data-RAM window back out as little-endian bytes.
module program_loader #(
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
  parameter int unsigned DUMP_WORDS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en_instr,
  output logic [31:0] addr_in_instr,
  output logic [31:0] data_in_instr,
  output logic        core_start,
  input  logic        core_end,
  output logic        memread_io,
  output logic        memwrite_io,
  output logic [31:0] addr_io,
  input  logic [31:0] data_from_memory_io,
  input  logic        data_ready_io,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  typedef enum logic [3:0] {
    ST_HDR, ST_LOAD, ST_WRITE, ST_RUN, ST_RD, ST_RDGAP, ST_RDWAIT, ST_TX, ST_FIN
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  byte_idx_r, byte_idx_s;
  logic [31:0] word_r, word_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] remaining_r, remaining_s;
  logic [31:0] raddr_r, raddr_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] shift_r, shift_s;
  logic        rx_ready_r, wr_en_r, core_start_r, memread_r, tx_valid_r, done_r;
  logic        rx_fire_s;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r        = w;
    endcase
    return r;
  endfunction

  assign rx_fire_s = rx_valid && rx_ready_r;

  // Next-state and datapath updates for the whole load / run / dump sequence.
  always_comb begin
    state_s     = state_r;
    byte_idx_s  = byte_idx_r;
    word_s      = word_r;
    addr_s      = addr_r;
    remaining_s = remaining_r;
    raddr_s     = raddr_r;
    cnt_s       = cnt_r;
    shift_s     = shift_r;
    case (state_r)
      ST_HDR: begin
        if (rx_fire_s) begin
          word_s     = put_byte(word_r, byte_idx_r, rx_data);
          byte_idx_s = byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) begin
            if (word_s == 32'd0) begin
              state_s = ST_RUN;
            end else begin
              state_s     = ST_LOAD;
              addr_s      = 32'd0;
              remaining_s = word_s;
            end
          end else begin
            state_s = ST_HDR;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (rx_fire_s) begin
          word_s     = put_byte(word_r, byte_idx_r, rx_data);
          byte_idx_s = byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        addr_s      = addr_r + 32'd4;
        remaining_s = remaining_r - 32'd1;
        if (remaining_r == 32'd1) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (core_end) begin
          raddr_s = DUMP_BASE;
          cnt_s   = DUMP_WORDS;
          if (DUMP_WORDS == 32'd0) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RD:    state_s = ST_RDGAP;
      // The RAM still shows ready the cycle after a request, so that cycle is skipped.
      ST_RDGAP: state_s = ST_RDWAIT;
      ST_RDWAIT: begin
        if (data_ready_io) begin
          shift_s    = data_from_memory_io;
          byte_idx_s = 2'd0;
          state_s    = ST_TX;
        end else begin
          state_s = ST_RDWAIT;
        end
      end
      ST_TX: begin
        if (tx_ready) begin
          shift_s    = {8'd0, shift_r[31:8]};
          byte_idx_s = byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) begin
            raddr_s = raddr_r + 32'd4;
            cnt_s   = cnt_r - 32'd1;
            if (cnt_r == 32'd1) begin
              state_s = ST_FIN;
            end else begin
              state_s = ST_RD;
            end
          end else begin
            state_s = ST_TX;
          end
        end else begin
          state_s = ST_TX;
        end
      end
      ST_FIN:  state_s = ST_FIN;
      default: begin
        state_s    = ST_HDR;
        byte_idx_s = 2'd0;
      end
    endcase
  end

  // State, datapath and output registers; strobes are decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_HDR;
      byte_idx_r   <= 2'd0;
      word_r       <= 32'd0;
      addr_r       <= 32'd0;
      remaining_r  <= 32'd0;
      raddr_r      <= 32'd0;
      cnt_r        <= 32'd0;
      shift_r      <= 32'd0;
      rx_ready_r   <= 1'b1;
      wr_en_r      <= 1'b0;
      core_start_r <= 1'b0;
      memread_r    <= 1'b0;
      tx_valid_r   <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_idx_r   <= byte_idx_s;
      word_r       <= word_s;
      addr_r       <= addr_s;
      remaining_r  <= remaining_s;
      raddr_r      <= raddr_s;
      cnt_r        <= cnt_s;
      shift_r      <= shift_s;
      rx_ready_r   <= (state_s == ST_HDR) || (state_s == ST_LOAD);
      wr_en_r      <= (state_s == ST_WRITE);
      core_start_r <= state_s inside {ST_RUN, ST_RD, ST_RDGAP, ST_RDWAIT, ST_TX, ST_FIN};
      memread_r    <= (state_s == ST_RD);
      tx_valid_r   <= (state_s == ST_TX);
      done_r       <= (state_s == ST_FIN);
    end
  end

  assign rx_ready      = rx_ready_r;
  assign wr_en_instr   = wr_en_r;
  assign addr_in_instr = addr_r;
  assign data_in_instr = word_r;
  assign core_start    = core_start_r;
  assign memread_io    = memread_r;
  assign memwrite_io   = 1'b0;
  assign addr_io       = raddr_r;
  assign tx_data       = shift_r[7:0];
  assign tx_valid      = tx_valid_r;
  assign done          = done_r;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random image/handshake stimulus, a byte/word-level reference model
// compared against the DUT every cycle, and a slow data-RAM model with a 3-cycle busy window.
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          DW   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en_instr;
  logic [31:0] addr_in_instr, data_in_instr;
  logic        core_start;
  logic        core_end = 1'b0;
  logic        memread_io, memwrite_io;
  logic [31:0] addr_io;
  logic [31:0] data_from_memory_io = 32'd0;
  logic        data_ready_io = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        done;

  program_loader #(.DUMP_BASE(BASE), .DUMP_WORDS(DW)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en_instr(wr_en_instr), .addr_in_instr(addr_in_instr), .data_in_instr(data_in_instr),
    .core_start(core_start), .core_end(core_end), .memread_io(memread_io),
    .memwrite_io(memwrite_io), .addr_io(addr_io), .data_from_memory_io(data_from_memory_io),
    .data_ready_io(data_ready_io), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int scen  = 0;
  logic [7:0] lit_tx [0:7] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hAABBCCDD;
    else if (a == 32'h104) return 32'h11223344;
    else return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (scenario %0d, t=%0t)", name, act, exp, scen, $time);
    end
  endtask

  // Reference model: expectations for the current cycle
  int          m_acc, m_wrote, m_left, m_age, m_txn, m_wd_cnt;
  logic [31:0] m_word, m_n, m_wa, m_wd, m_raddr;
  logic        m_rdy, m_wr, m_run, m_dump, m_rd, m_pend, m_done;
  logic [7:0]  m_txq[$];
  logic        n_wr, n_run, n_rd, n_done, n_pend;
  int          n_age;
  logic [31:0] w_tmp;

  task automatic m_reset();
    m_acc = 0; m_wrote = 0; m_left = 0; m_age = 0; m_txn = 0; m_wd_cnt = 0;
    m_word = 32'd0; m_n = 32'd0; m_wa = 32'd0; m_wd = 32'd0; m_raddr = 32'd0;
    m_rdy = 1'b1; m_wr = 1'b0; m_run = 1'b0; m_dump = 1'b0; m_rd = 1'b0;
    m_pend = 1'b0; m_done = 1'b0;
    m_txq.delete();
  endtask

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      m_reset();
      #1;
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_wr_en", wr_en_instr, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_memread", memread_io, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_done", done, 0);
    end else begin
      chk("rx_ready", rx_ready, m_rdy);
      chk("wr_en", wr_en_instr, m_wr);
      if (m_wr) begin
        chk("wr_addr", addr_in_instr, m_wa);
        chk("wr_data", data_in_instr, m_wd);
        if (scen == 1) begin
          chk("lit_wr_addr", addr_in_instr, 32'd0);
          chk("lit_wr_data", data_in_instr, 32'h12345678);
        end
      end
      chk("core_start", core_start, m_run);
      chk("memread", memread_io, m_rd);
      chk("memwrite", memwrite_io, 0);
      if (m_rd || m_pend) chk("addr_io", addr_io, m_raddr);
      chk("tx_valid", tx_valid, m_txq.size() != 0);
      if (m_txq.size() != 0) chk("tx_data", tx_data, m_txq[0]);
      chk("done", done, m_done);

      n_wr = 1'b0; n_run = m_run; n_rd = 1'b0; n_done = 1'b0;
      n_pend = m_pend; n_age = m_age;
      // input side: byte stream -> header count and words
      if (rx_valid && m_rdy) begin
        m_word[8*(m_acc%4) +: 8] = rx_data;
        m_acc++;
        if (m_acc == 4) begin
          m_n = m_word;
          if (m_n == 32'd0) n_run = 1'b1;
        end else if (m_acc > 4 && m_acc % 4 == 0) begin
          m_wa = 32'(4 * (m_acc / 4 - 2));
          m_wd = m_word;
          n_wr = 1'b1;
        end
      end
      if (m_wr) begin
        m_wrote++;
        if (m_wrote == m_n) n_run = 1'b1;
      end
      // output side: dump window word by word
      if (m_run && !m_dump && core_end) begin
        m_dump = 1'b1; m_left = DW; m_raddr = BASE;
        if (DW == 0) n_done = 1'b1;
        else n_rd = 1'b1;
      end
      if (m_txq.size() != 0 && tx_ready) begin
        if (scen == 1 && m_txn < 8) chk("lit_tx", tx_data, lit_tx[m_txn]);
        m_txn++;
        void'(m_txq.pop_front());
        if (m_txq.size() == 0) begin
          m_left--;
          m_raddr = m_raddr + 32'd4;
          if (m_left == 0) n_done = 1'b1;
          else n_rd = 1'b1;
        end
      end
      if (m_rd) begin
        n_pend = 1'b1; n_age = 1;
      end else if (m_pend) begin
        if (m_age >= 2 && data_ready_io) begin
          w_tmp = mem_word(m_raddr);
          for (int i = 0; i < 4; i++) m_txq.push_back(w_tmp[8*i +: 8]);
          n_pend = 1'b0;
        end else begin
          n_age = m_age + 1;
        end
      end
      if (m_dump && !m_done) begin
        m_wd_cnt++;
        if (m_wd_cnt == 3000) begin
          tests++; fails++;
          $display("FAIL dump_timeout: done still 0 after %0d cycles, required 1", m_wd_cnt);
        end
      end
      m_wr = n_wr; m_run = n_run; m_rd = n_rd; m_pend = n_pend; m_age = n_age;
      m_done = m_done | n_done;
      m_rdy = !n_run && !n_wr;
    end
  end

  // Data RAM: ready stays high the cycle after a request, then low 3 cycles; junk data until valid
  initial begin : ram_model
    int          rcnt;
    logic        req;
    logic [31:0] a, ram_addr;
    rcnt = 8; ram_addr = 32'd0;
    forever begin
      @(negedge clk);
      req = memread_io; a = addr_io;
      @(posedge clk); #1;
      if (req) begin rcnt = 0; ram_addr = a; end
      else if (rcnt < 8) rcnt++;
      data_ready_io = !(rcnt >= 1 && rcnt <= 3);
      data_from_memory_io = (rcnt >= 4) ? mem_word(ram_addr) : $urandom;
    end
  end

  initial begin : tx_driver
    int   hold, hs_n;
    logic hs;
    hold = 0; hs_n = 0;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready;
      if (hs) hs_n++;
      if (scen == 1 && hs && hs_n == 2) hold = 10;
      @(posedge clk); #1;
      if (hold > 0) begin tx_ready = 1'b0; hold--; end
      else tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    rx_valid = 1'b0;
    cyc(gap);
    rx_valid = 1'b1; rx_data = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); got = rx_ready;
      @(posedge clk); #1;
      if (got) break;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, gapmax));
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; core_end = 1'b0;
    @(posedge clk); #2; rstn = 1'b0; #2; rstn = 1'b1;
  endtask

  task automatic run_image(input logic [31:0] words[$], input int gapmax, input bit early_end);
    send_word(32'(words.size()), gapmax);
    if (early_end) core_end = 1'b1;
    foreach (words[i]) send_word(words[i], gapmax);
    rx_valid = 1'b1; rx_data = 8'hEE;
    cyc(4);
    rx_valid = 1'b0;
    cyc($urandom_range(1, 4));
    core_end = 1'b1;
    for (int i = 0; i < 3000 && done !== 1'b1; i++) cyc(1);
    core_end = 1'b0;
    cyc(3);
  endtask

  initial begin : stim
    logic [31:0] q[$];
    cyc(3);
    rstn = 1'b1;
    scen = 1;
    q = '{32'h12345678};
    run_image(q, 0, 1'b0);
    scen = 2; do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    run_image(q, 2, 1'b1);
    scen = 3; do_reset();
    q.delete();
    run_image(q, 1, 1'b0);
    scen = 4; do_reset();
    send_word(32'd4, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    rx_valid = 1'b0;
    cyc(2);
    do_reset();
    q.delete();
    for (int i = 0; i < 2; i++) q.push_back($urandom);
    run_image(q, 1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      scen = 5 + s; do_reset();
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) q.push_back($urandom);
      run_image(q, 2, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot/IO controller that sits directly upstream of the instruction and data RAMs.
- Receives a program image as a byte stream from the UART receiver and writes it word-by-word into instruction RAM.
- Raises core_start, then waits for core_end.
- After core_end, reads a fixed window of data RAM through the IO port and streams it out to the UART transmitter as bytes.

Parameters:
- DUMP_BASE, 32'h0000_0000, byte address of the first data-RAM word dumped after core_end.
- DUMP_WORDS, 16, number of 32-bit words dumped; 0 means no dump.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; byte consumed when rx_valid && rx_ready
- rx_ready  out  1  loader can accept a byte
- wr_en_instr  out  1  instruction RAM write strobe
- addr_in_instr  out  32  instruction RAM byte address
- data_in_instr  out  32  instruction RAM write data
- core_start  out  1  core run enable (level)
- core_end  in  1  core finished (level, sampled)
- memread_io  out  1  data RAM IO read request (1-cycle pulse)
- memwrite_io  out  1  data RAM IO write; always 0 in this block
- addr_io  out  32  data RAM IO byte address
- data_from_memory_io  in  32  data RAM read data
- data_ready_io  in  1  data RAM not busy with an IO read
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte this cycle
- done  out  1  dump complete (level, sticky until reset)

Behaviour:
- Reset (async, rstn=0):
  - state=HDR, byte index=0.
  - All outputs 0 except rx_ready=1.
  - Reset mid-operation aborts immediately, drops core_start, and discards any partial word.
- Byte assembly: little-endian. The first accepted byte goes to [7:0], the fourth to [31:24]. The 2-bit byte index wraps after 4.
- HDR:
  - rx_ready=1.
  - Collect 4 bytes into the 32-bit word count N.
  - On the 4th byte: if N==0, go to RUN; else go to LOAD with addr=0 and remaining=N.
- LOAD:
  - rx_ready=1.
  - On the 4th byte of each word, go to WRITE the next cycle.
- WRITE (exactly 1 cycle):
  - wr_en_instr=1, addr_in_instr=addr, data_in_instr=assembled word; rx_ready=0.
  - Then addr+=4 (32-bit wrap) and remaining-=1.
  - remaining reaching 0 → RUN, else → LOAD.
  - Address bits above [15:2] are ignored by the RAM, so images over 16384 words overwrite from 0; this is not flagged.
- RUN:
  - rx_ready=0; core_start=1, registered and held from entry until reset.
  - Bytes arriving are not accepted.
  - When core_end=1 is sampled: go to RD with raddr=DUMP_BASE and cnt=DUMP_WORDS; if DUMP_WORDS==0, go to FIN.
- Data-RAM read sequence, needed because the RAM deasserts data_ready_io one cycle after a request and re-asserts it three cycles later:
  - RD: memread_io=1 for one cycle, addr_io=raddr. Go to RDGAP.
  - RDGAP: 1 cycle, ignore data_ready_io. Go to RDWAIT.
  - RDWAIT: when data_ready_io=1, latch data_from_memory_io into the shift register and go to TX with byte index 0.
  - addr_io holds raddr throughout RD..RDWAIT; memwrite_io=0 always.
- TX:
  - tx_valid=1, tx_data=shift[7:0].
  - On tx_ready: shift right by 8; after the 4th byte, raddr+=4 and cnt-=1.
  - cnt reaching 0 → FIN, else → RD.
  - tx_data is stable while tx_valid && !tx_ready.
- FIN: done=1, core_start stays 1, all strobes 0. Terminal until reset.
- Latency:
  - The last instruction byte accepted at cycle t gives wr_en_instr at t+1 and core_start=1 from t+2.
  - Each dumped word takes at least 4 read cycles plus 4 tx handshakes.
- Simultaneous events: core_end is only observed in RUN; an asserted core_end during HDR/LOAD has no effect until RUN.

Test Plan:
- Bytes 01 00 00 00, 78 56 34 12 → one write, addr_in_instr=0, data_in_instr=32'h12345678, wr_en_instr high exactly 1 cycle; core_start=1 two cycles after the last byte.
- N=3 with words A,B,C → writes at addresses 0,4,8 in order; rx_ready=0 during each WRITE cycle; a rx_valid held across WRITE is accepted afterwards, with no byte lost or duplicated.
- N=0 header → no wr_en_instr; core_start=1 the cycle after the 4th byte.
- DUMP_BASE=32'h100, DUMP_WORDS=2, RAM model returning 32'hAABBCCDD and 32'h11223344 with 3-cycle busy → memread_io pulses at addr_io 0x100 then 0x104; tx bytes DD CC BB AA 44 33 22 11; done=1 after the last tx_ready.
- tx_ready held low 10 cycles mid-word → tx_valid stays 1, tx_data unchanged, no extra memread_io.
- rstn pulsed low during LOAD after 2 of 4 bytes (asynchronous, mid-cycle) → outputs clear immediately; a new header is accepted from byte index 0, and stale bytes do not appear in the next written word.
